// File: rtl/pipe_phy_cmd_responder.sv
// PHY-side PIPE command responder: answers rate, powerdown and receiver-detect
// requests with a one-cycle phystatus pulse (and rxstatus for detect), and
// holds phystatus/phystatus_rst high through the post-reset window.
// Latency: request visible at edge N -> phystatus pulse in cycle N+1+<op>_LATENCY.
// Backpressure: none; requests arriving while busy are re-evaluated on return to IDLE.
//
// Ports:
//   clk_i, rst_ni         PCLK, async active-low reset
//   phy_txdetectrx_i      receiver-detect request (level, acted on at rising edge)
//   phy_txelecidle_i      per-lane TX electrical idle (must be all ones for detect)
//   phy_powerdown_i       requested power state (00=P0, 01=P0s, 10=P1, 11=P2)
//   phy_rate_i            requested rate
//   lane_present_i        far-end receiver present per lane (model input)
//   phy_phystatus_o       completion pulse, all lanes together
//   phy_rxstatus_o        3 bits per lane, non-zero only in the response cycle
//   phy_phystatus_rst_o   high while in the post-reset window
//   phy_rxelecidle_o      per-lane RX electrical idle (registered)
//   busy_o                high whenever the FSM is not IDLE
//   err_o                 sticky: detect requested outside P1 or without TX elec idle
module pipe_phy_cmd_responder #(
   parameter int MAX_NUM_LANES  = 1,
   parameter int RST_CYCLES     = 16,
   parameter int DETECT_LATENCY = 4,
   parameter int PD_LATENCY     = 2,
   parameter int RATE_LATENCY   = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       phy_txdetectrx_i,
   input  logic [MAX_NUM_LANES-1:0]   phy_txelecidle_i,
   input  logic [1:0]                 phy_powerdown_i,
   input  logic [2:0]                 phy_rate_i,
   input  logic [MAX_NUM_LANES-1:0]   lane_present_i,
   output logic [MAX_NUM_LANES-1:0]   phy_phystatus_o,
   output logic [3*MAX_NUM_LANES-1:0] phy_rxstatus_o,
   output logic                       phy_phystatus_rst_o,
   output logic [MAX_NUM_LANES-1:0]   phy_rxelecidle_o,
   output logic                       busy_o,
   output logic                       err_o
);

   // One counter serves every timed state, so it is sized for the longest wait.
   localparam int MAX_A  = (RST_CYCLES > DETECT_LATENCY) ? RST_CYCLES : DETECT_LATENCY;
   localparam int MAX_B  = (PD_LATENCY > RATE_LATENCY) ? PD_LATENCY : RATE_LATENCY;
   localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W  = $clog2(MAX_LAT + 1);

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] DET_LAST  = CNT_W'(DETECT_LATENCY);
   localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(PD_LATENCY);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_LATENCY);

   localparam logic [1:0] PD_P0 = 2'b00;
   localparam logic [1:0] PD_P1 = 2'b10;

   typedef enum logic [2:0] {
      ST_RST_WAIT,
      ST_IDLE,
      ST_DETECT,
      ST_PD_CHG,
      ST_RATE_CHG,
      ST_RESP,
      ST_DET_HOLD
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
   logic [1:0]                 pd_q, pd_d, pd_tgt_q, pd_tgt_d;
   logic [2:0]                 rate_q, rate_d, rate_tgt_q, rate_tgt_d;
   logic                       det_op_q, det_op_d;
   logic                       det_prev_q, det_prev_d;
   logic                       err_q, err_d;
   logic [MAX_NUM_LANES-1:0]   rxei_q, rxei_d;
   logic                       det_rise;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_RST_WAIT;
         cnt_q      <= '0;
         pd_q       <= PD_P1;
         pd_tgt_q   <= PD_P1;
         rate_q     <= '0;
         rate_tgt_q <= '0;
         det_op_q   <= 1'b0;
         det_prev_q <= 1'b0;
         err_q      <= 1'b0;
         rxei_q     <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pd_q       <= pd_d;
         pd_tgt_q   <= pd_tgt_d;
         rate_q     <= rate_d;
         rate_tgt_q <= rate_tgt_d;
         det_op_q   <= det_op_d;
         det_prev_q <= det_prev_d;
         err_q      <= err_d;
         rxei_q     <= rxei_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      pd_d       = pd_q;
      pd_tgt_d   = pd_tgt_q;
      rate_d     = rate_q;
      rate_tgt_d = rate_tgt_q;
      det_op_d   = det_op_q;
      err_d      = err_q;
      // The delayed copy tracks the input in every state, so a request held
      // across a busy period (or a reset window) never looks like a new edge.
      det_prev_d = phy_txdetectrx_i;
      det_rise   = phy_txdetectrx_i & ~det_prev_q;
      cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         ST_RST_WAIT: begin
            cnt_d = cnt_inc;
            if (cnt_q == RST_LAST) begin
               state_d = ST_IDLE;
               rate_d  = phy_rate_i;
               pd_d    = phy_powerdown_i;
            end
         end
         ST_IDLE: begin
            if (phy_rate_i != rate_q) begin
               state_d    = ST_RATE_CHG;
               rate_tgt_d = phy_rate_i;
               det_op_d   = 1'b0;
            end else if (phy_powerdown_i != pd_q) begin
               state_d  = ST_PD_CHG;
               pd_tgt_d = phy_powerdown_i;
               det_op_d = 1'b0;
            end else if (det_rise) begin
               if (pd_q == PD_P1 && (&phy_txelecidle_i)) begin
                  state_d  = ST_DETECT;
                  det_op_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DETECT: begin
            cnt_d = cnt_inc;
            if (cnt_q == DET_LAST) state_d = ST_RESP;
         end
         ST_PD_CHG: begin
            cnt_d = cnt_inc;
            if (cnt_q == PD_LAST) begin
               state_d = ST_RESP;
               pd_d    = pd_tgt_q;
            end
         end
         ST_RATE_CHG: begin
            cnt_d = cnt_inc;
            if (cnt_q == RATE_LAST) begin
               state_d = ST_RESP;
               rate_d  = rate_tgt_q;
            end
         end
         ST_RESP: begin
            state_d = det_op_q ? ST_DET_HOLD : ST_IDLE;
         end
         ST_DET_HOLD: begin
            if (!phy_txdetectrx_i) state_d = ST_IDLE;
         end
         default: state_d = ST_RST_WAIT;
      endcase

      for (int i = 0; i < MAX_NUM_LANES; i++) begin
         rxei_d[i] = ~(lane_present_i[i] & (pd_q == PD_P0) & (state_q != ST_RST_WAIT));
      end
   end

   // Status decode straight from the state register; lane presence is
   // taken live during the response cycle.
   always_comb begin
      phy_rxstatus_o = '0;
      if (state_q == ST_RESP && det_op_q) begin
         for (int i = 0; i < MAX_NUM_LANES; i++) begin
            if (lane_present_i[i]) phy_rxstatus_o[3*i +: 3] = 3'b011;
         end
      end
   end

   assign phy_phystatus_o     = {MAX_NUM_LANES{(state_q == ST_RST_WAIT) || (state_q == ST_RESP)}};
   assign phy_phystatus_rst_o = (state_q == ST_RST_WAIT);
   assign phy_rxelecidle_o    = rxei_q;
   assign busy_o              = (state_q != ST_IDLE);
   assign err_o               = err_q;

endmodule

// File: tb/tb_pipe_phy_cmd_responder.sv
// Bench for pipe_phy_cmd_responder: transaction table, hand-written corner
// sequences (reset window, simultaneous requests, illegal detect, reset
// mid-detect) and a randomized run against a cycle-indexed reference model.
module tb_pipe_phy_cmd_responder;
   localparam int L     = 2;
   localparam int RSTC  = 16;
   localparam int DETL  = 4;
   localparam int PDL   = 2;
   localparam int RATEL = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           txdet;
   logic [L-1:0]   txe;
   logic [1:0]     pd;
   logic [2:0]     rate;
   logic [L-1:0]   lp;
   logic [L-1:0]   phys;
   logic [3*L-1:0] rxs;
   logic           phys_rst;
   logic [L-1:0]   rxei;
   logic           busy;
   logic           err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_phy_cmd_responder #(
      .MAX_NUM_LANES (L),
      .RST_CYCLES    (RSTC),
      .DETECT_LATENCY(DETL),
      .PD_LATENCY    (PDL),
      .RATE_LATENCY  (RATEL)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .phy_txdetectrx_i   (txdet),
      .phy_txelecidle_i   (txe),
      .phy_powerdown_i    (pd),
      .phy_rate_i         (rate),
      .lane_present_i     (lp),
      .phy_phystatus_o    (phys),
      .phy_rxstatus_o     (rxs),
      .phy_phystatus_rst_o(phys_rst),
      .phy_rxelecidle_o   (rxei),
      .busy_o             (busy),
      .err_o              (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for the next phystatus pulse; lat counts clocks from the edge at
   // which the request became visible (the first edge after it was driven).
   task automatic wait_pulse(output int lat, output logic [3*L-1:0] rx);
      lat = -1;
      rx  = '0;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (phys != '0) begin
            lat = k - 1;
            rx  = rxs;
            break;
         end
      end
   endtask

   // Asserts reset at the current time, checks the asynchronous reset values,
   // releases and measures the phystatus_rst window.
   task automatic reset_and_check(input string tag);
      int fall_k;
      logic [L-1:0] prev_phys;
      rst_n = 1'b0;
      txdet = 1'b0;
      txe   = '1;
      pd    = 2'b10;
      rate  = 3'd0;
      lp    = 2'b01;
      #1;
      check({tag, " rst phystatus"}, 32'(phys), 32'(2'b11));
      check({tag, " rst rxstatus"}, 32'(rxs), 32'd0);
      check({tag, " rst phystatus_rst"}, 32'(phys_rst), 32'd1);
      check({tag, " rst rxelecidle"}, 32'(rxei), 32'(2'b11));
      check({tag, " rst busy"}, 32'(busy), 32'd1);
      check({tag, " rst err"}, 32'(err), 32'd0);
      step();
      step();
      rst_n     = 1'b1;
      fall_k    = -1;
      prev_phys = '0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (!phys_rst) begin
            fall_k = k;
            break;
         end
         prev_phys = phys;
      end
      check({tag, " rst window clocks"}, 32'(fall_k), 32'(RSTC));
      check({tag, " phystatus before fall"}, 32'(prev_phys), 32'(2'b11));
      check({tag, " phystatus after fall"}, 32'(phys), 32'd0);
      check({tag, " busy after fall"}, 32'(busy), 32'd0);
   endtask

   // ---------------- reference model for the randomized run ----------------
   // Tracks absolute cycle numbers: a request accepted at edge N produces the
   // pulse in cycle N+1+latency; mode 0 idle, 1 waiting for pulse, 2 detect hold.
   int           m_cyc = 0;
   int           m_rst_left, m_mode, m_op, m_pulse_at;
   logic [2:0]   m_rate, m_rate_tgt;
   logic [1:0]   m_pd, m_pd_tgt;
   logic         m_err, m_prev_det;
   logic [L-1:0] m_rxei;

   task automatic model_reset();
      m_rst_left = RSTC;
      m_mode     = 0;
      m_op       = 0;
      m_pulse_at = -10;
      m_pd       = 2'b10;
      m_rate     = 3'd0;
      m_err      = 1'b0;
      m_prev_det = 1'b0;
      m_rxei     = '1;
   endtask

   task automatic model_start(input int op, input int lat);
      m_mode     = 1;
      m_op       = op;
      m_pulse_at = m_cyc + 1 + lat;
      m_rate_tgt = rate;
      m_pd_tgt   = pd;
   endtask

   task automatic model_edge();
      m_cyc++;
      for (int i = 0; i < L; i++) m_rxei[i] = !(lp[i] && m_pd == 2'b00 && m_rst_left == 0);
      if (m_rst_left > 0) begin
         m_rst_left--;
         if (m_rst_left == 0) begin
            m_rate = rate;
            m_pd   = pd;
         end
      end else if (m_mode == 1) begin
         if (m_cyc == m_pulse_at) begin
            if (m_op == 0) m_rate = m_rate_tgt;
            if (m_op == 1) m_pd = m_pd_tgt;
         end else if (m_cyc == m_pulse_at + 1) begin
            m_mode = (m_op == 2) ? 2 : 0;
         end
      end else if (m_mode == 2) begin
         if (!txdet) m_mode = 0;
      end else begin
         if (rate != m_rate) model_start(0, RATEL);
         else if (pd != m_pd) model_start(1, PDL);
         else if (txdet && !m_prev_det) begin
            if (m_pd == 2'b10 && txe == '1) model_start(2, DETL);
            else m_err = 1'b1;
         end
      end
      m_prev_det = txdet;
   endtask

   function automatic logic [12:0] model_expect();
      logic           in_pulse;
      logic [L-1:0]   e_phys;
      logic [3*L-1:0] e_rxs;
      in_pulse = (m_mode == 1) && (m_cyc == m_pulse_at);
      e_phys   = (m_rst_left > 0 || in_pulse) ? '1 : '0;
      e_rxs    = '0;
      if (in_pulse && m_op == 2)
         for (int i = 0; i < L; i++) if (lp[i]) e_rxs[3*i +: 3] = 3'b011;
      return {e_phys, e_rxs, (m_rst_left > 0), m_rxei, (m_rst_left > 0 || m_mode != 0), m_err};
   endfunction

   // ---------------- transaction table ----------------
   typedef struct {
      int             op;        // 0 rate, 1 powerdown, 2 detect
      logic [2:0]     val;
      logic [L-1:0]   lp;
      int             exp_lat;
      logic [3*L-1:0] exp_rxs;
      logic [L-1:0]   exp_rxei;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int             lat, npulse, first, second;
      logic [3*L-1:0] rx;

      tbl[0] = '{2, 3'd0, 2'b01, DETL + 1,  6'b000_011, 2'b11};
      tbl[1] = '{2, 3'd0, 2'b10, DETL + 1,  6'b011_000, 2'b11};
      tbl[2] = '{2, 3'd0, 2'b11, DETL + 1,  6'b011_011, 2'b11};
      tbl[3] = '{0, 3'd3, 2'b01, RATEL + 1, 6'b000_000, 2'b11};
      tbl[4] = '{1, 3'd0, 2'b01, PDL + 1,   6'b000_000, 2'b10};
      tbl[5] = '{1, 3'd2, 2'b11, PDL + 1,   6'b000_000, 2'b11};
      tbl[6] = '{0, 3'd0, 2'b11, RATEL + 1, 6'b000_000, 2'b11};
      tbl[7] = '{2, 3'd0, 2'b00, DETL + 1,  6'b000_000, 2'b11};
      tbl[8] = '{1, 3'd0, 2'b11, PDL + 1,   6'b000_000, 2'b00};
      tbl[9] = '{1, 3'd2, 2'b11, PDL + 1,   6'b000_000, 2'b11};

      rst_n = 1'b0;
      txdet = 1'b0;
      txe   = '1;
      pd    = 2'b10;
      rate  = 3'd0;
      lp    = 2'b01;
      step();

      // Reset values and the post-reset phystatus window.
      reset_and_check("T1");

      // Table of single transactions.
      for (int r = 0; r < 10; r++) begin
         lp = tbl[r].lp;
         case (tbl[r].op)
            0:       rate = tbl[r].val;
            1:       pd = tbl[r].val[1:0];
            default: txdet = 1'b1;
         endcase
         wait_pulse(lat, rx);
         check($sformatf("row%0d latency", r), 32'(lat), 32'(tbl[r].exp_lat));
         check($sformatf("row%0d rxstatus", r), 32'(rx), 32'(tbl[r].exp_rxs));
         step();
         check($sformatf("row%0d single pulse", r), 32'(phys), 32'd0);
         if (tbl[r].op == 2) begin
            step();
            check($sformatf("row%0d busy in detect hold", r), 32'(busy), 32'd1);
            txdet = 1'b0;
         end
         step();
         step();
         check($sformatf("row%0d busy after", r), 32'(busy), 32'd0);
         check($sformatf("row%0d rxelecidle", r), 32'(rxei), 32'(tbl[r].exp_rxei));
         check($sformatf("row%0d rxstatus idle", r), 32'(rxs), 32'd0);
      end
      check("table err", 32'(err), 32'd0);

      // Rate and powerdown change on the same edge: rate first, then powerdown
      // once the FSM is back in IDLE (IDLE entry edge + arbitration edge).
      lp     = 2'b01;
      rate   = 3'd1;
      pd     = 2'b00;
      npulse = 0;
      first  = -1;
      second = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (phys != '0) begin
            npulse++;
            if (first < 0) first = k - 1;
            else if (second < 0) second = k - 1;
         end
      end
      check("T4 pulse count", 32'(npulse), 32'd2);
      check("T4 rate latency", 32'(first), 32'(RATEL + 1));
      check("T4 pd pulse gap", 32'(second - first), 32'(PDL + 3));
      check("T4 rxelecidle", 32'(rxei), 32'(2'b10));

      // Detect requested in P0: dropped, err set and sticky.
      txdet  = 1'b1;
      npulse = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (phys != '0) npulse++;
      end
      check("T5 no pulse", 32'(npulse), 32'd0);
      check("T5 err set", 32'(err), 32'd1);
      check("T5 not busy", 32'(busy), 32'd0);
      txdet = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("T5 err sticky", 32'(err), 32'd1);

      // Reset two clocks into DETECT.
      reset_and_check("T6a");
      txdet = 1'b1;
      step();
      step();
      check("T6 busy in detect", 32'(busy), 32'd1);
      reset_and_check("T6b");
      npulse = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (phys != '0) npulse++;
      end
      check("T6 no stray pulse", 32'(npulse), 32'd0);

      // Randomized run against the reference model.
      begin
         int rst_hold;
         rst_hold = 3;
         rst_n    = 1'b0;
         model_reset();
         for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            if (!rst_n) begin
               if (rst_hold > 0) rst_hold--;
               else rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
               rst_n    = 1'b0;
               rst_hold = 1;
            end
            if ($urandom_range(0, 39) == 0) rate = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 29) == 0) pd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) txdet = ~txdet;
            txe = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            lp  = 2'($urandom_range(0, 3));
            if (!rst_n) model_reset();
            #1;
            check($sformatf("rand cycle %0d {phys,rxs,rst,rxei,busy,err}", c),
                  32'({phys, rxs, phys_rst, rxei, busy, err}), 32'(model_expect()));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
